// File: rtl/super_stack.sv
// super_stack: synchronous LIFO operand/frame stack.
//
// A frame is protected by raising underflow_limit: entries at or below the
// limit cannot be popped or replaced. Absolute index reload and direct access
// to entries anywhere below the top are also supported. All outputs are
// registered; an op presented before a rising edge is reflected after it.
//
// Ports
//   clk              single clock, rising edge
//   reset            synchronous active-low reset (index and status only)
//   op               NONE/PUSH/POP/REPLACE/INDEX_RESET/INDEX_RESET_AND_PUSH/
//                    UNDERFLOW_GET/UNDERFLOW_SET
//   data             write data
//   offset           absolute entry address for UNDERFLOW_GET/SET
//   underflow_limit  frame base; index == limit is an empty frame
//   new_index        reload value for INDEX_RESET*
//   index            number of stored entries (top = mem[index-1])
//   out/out1/out2    top, second and third entry
//   status           NONE/EMPTY/FULL/OVERFLOW/UNDERFLOW
module super_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [DEPTH:0]   offset,
    input  logic [DEPTH:0]   underflow_limit,
    input  logic [DEPTH:0]   new_index,
    output logic [DEPTH:0]   index,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [2:0]       status
);
    localparam int IW = DEPTH + 1;
    // Capacity is 2^IW - 1, i.e. the all-ones index value.
    localparam logic [IW-1:0] MAX_IDX = '1;

    localparam logic [2:0] OP_NONE      = 3'd0;
    localparam logic [2:0] OP_PUSH      = 3'd1;
    localparam logic [2:0] OP_POP       = 3'd2;
    localparam logic [2:0] OP_REPLACE   = 3'd3;
    localparam logic [2:0] OP_IRESET    = 3'd4;
    localparam logic [2:0] OP_IRESET_PU = 3'd5;
    localparam logic [2:0] OP_UF_GET    = 3'd6;
    localparam logic [2:0] OP_UF_SET    = 3'd7;

    localparam logic [2:0] ST_NONE      = 3'd0;
    localparam logic [2:0] ST_EMPTY     = 3'd1;
    localparam logic [2:0] ST_FULL      = 3'd2;
    localparam logic [2:0] ST_OVERFLOW  = 3'd3;
    localparam logic [2:0] ST_UNDERFLOW = 3'd4;

    // The array has 2^IW entries so every index value (including wrapped
    // negative addresses) is in range; the top entry is never written.
    logic [WIDTH-1:0] mem [0:(1<<IW)-1];

    logic [IW-1:0]    index_q  = '0;
    logic [2:0]       status_q = ST_EMPTY;
    logic [WIDTH-1:0] out_q, out1_q, out2_q;

    logic [IW-1:0]    n_index;
    logic [WIDTH-1:0] n_out, n_out1, n_out2;
    logic [2:0]       n_status;
    logic             rejected;
    logic [2:0]       reject_code;
    logic             we;
    logic [IW-1:0]    waddr;
    logic [IW-1:0]    im1, im2, im3, im4, nm1, nm2;

    assign im1 = index_q - IW'(1);
    assign im2 = index_q - IW'(2);
    assign im3 = index_q - IW'(3);
    assign im4 = index_q - IW'(4);
    assign nm1 = new_index - IW'(1);
    assign nm2 = new_index - IW'(2);

    always_comb begin
        n_index     = index_q;
        n_out       = out_q;
        n_out1      = out1_q;
        n_out2      = out2_q;
        rejected    = 1'b0;
        reject_code = ST_UNDERFLOW;
        we          = 1'b0;
        waddr       = index_q;
        case (op)
            OP_NONE: begin
                if (index_q >= underflow_limit) begin
                    n_out  = mem[im1];
                    n_out1 = mem[im2];
                    n_out2 = mem[im3];
                end
            end
            OP_PUSH: begin
                if (index_q == MAX_IDX) begin
                    rejected    = 1'b1;
                    reject_code = ST_OVERFLOW;
                end else begin
                    we      = 1'b1;
                    waddr   = index_q;
                    n_index = index_q + IW'(1);
                    n_out   = data;
                    n_out1  = mem[im1];
                    n_out2  = mem[im2];
                end
            end
            OP_POP: begin
                if (index_q <= underflow_limit) begin
                    rejected = 1'b1;
                end else begin
                    n_index = im1;
                    n_out   = mem[im2];
                    n_out1  = mem[im3];
                    n_out2  = mem[im4];
                end
            end
            OP_REPLACE: begin
                if (index_q <= underflow_limit) begin
                    rejected = 1'b1;
                end else begin
                    we     = 1'b1;
                    waddr  = im1;
                    n_out  = data;
                    n_out1 = mem[im2];
                    n_out2 = mem[im3];
                end
            end
            OP_IRESET: begin
                n_index = new_index;
            end
            OP_IRESET_PU: begin
                if (new_index == MAX_IDX) begin
                    rejected    = 1'b1;
                    reject_code = ST_OVERFLOW;
                end else begin
                    we      = 1'b1;
                    waddr   = new_index;
                    n_index = new_index + IW'(1);
                    n_out   = data;
                    n_out1  = mem[nm1];
                    n_out2  = mem[nm2];
                end
            end
            OP_UF_GET: begin
                if (offset >= index_q) rejected = 1'b1;
                else                   n_out = mem[offset];
            end
            default: begin
                if (offset >= index_q) begin
                    rejected = 1'b1;
                end else begin
                    we    = 1'b1;
                    waddr = offset;
                    n_out = data;
                end
            end
        endcase

        // EMPTY is tested before FULL so a frame base at capacity reads EMPTY.
        if (rejected)                        n_status = reject_code;
        else if (n_index < underflow_limit)  n_status = ST_UNDERFLOW;
        else if (n_index == underflow_limit) n_status = ST_EMPTY;
        else if (n_index == MAX_IDX)         n_status = ST_FULL;
        else                                 n_status = ST_NONE;
    end

    // Reset clears only index and status; stored data and the output
    // registers survive so a frame can be re-established after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            index_q  <= '0;
            status_q <= ST_EMPTY;
        end else begin
            index_q  <= n_index;
            status_q <= n_status;
            out_q    <= n_out;
            out1_q   <= n_out1;
            out2_q   <= n_out2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && we) mem[waddr] <= data;
    end

    assign index  = index_q;
    assign status = status_q;
    assign out    = out_q;
    assign out1   = out1_q;
    assign out2   = out2_q;
endmodule

// File: tb/tb_super_stack.sv
module tb_super_stack;
    localparam int MAXS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] data = 8'd0;
    logic [1:0] offset = 2'd0;
    logic [1:0] underflow_limit = 2'd0;
    logic [1:0] new_index = 2'd0;
    logic [1:0] index;
    logic [7:0] out, out1, out2;
    logic [2:0] status;

    super_stack #(.WIDTH(8), .DEPTH(1)) dut (
        .clk(clk), .reset(reset), .op(op), .data(data), .offset(offset),
        .underflow_limit(underflow_limit), .new_index(new_index),
        .index(index), .out(out), .out1(out1), .out2(out2), .status(status)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: plain integers, unwritten/negative reads are unknown.
    int m_idx = 0;
    int m_status = 1;
    int m_mem[MAXS];
    bit m_wr[MAXS];
    int m_out[3];
    bit m_ov[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic rd(input int a, output int v, output bit ok);
        ok = (a >= 0) && (a < MAXS) && m_wr[a];
        v  = ok ? m_mem[a] : 0;
    endtask

    task automatic set_out(input int k, input int a);
        int v; bit ok;
        rd(a, v, ok);
        m_out[k] = v;
        m_ov[k]  = ok;
    endtask

    task automatic put_top(input int d);
        m_out[0] = d;
        m_ov[0]  = 1'b1;
    endtask

    task automatic wr(input int a, input int d);
        m_mem[a] = d;
        m_wr[a]  = 1'b1;
    endtask

    task automatic model(input int o, input int d, input int off, input int lim,
                         input int ni, input bit rst);
        int i, n, code;
        bit rej;
        if (rst) begin
            m_idx = 0;
            m_status = 1;
            return;
        end
        i = m_idx; n = i; rej = 0; code = 4;
        case (o)
            0: if (i >= lim) begin set_out(0, i-1); set_out(1, i-2); set_out(2, i-3); end
            1: if (i == MAXS) begin rej = 1; code = 3; end
               else begin wr(i, d); n = i + 1; put_top(d); set_out(1, i-1); set_out(2, i-2); end
            2: if (i <= lim) rej = 1;
               else begin n = i - 1; set_out(0, i-2); set_out(1, i-3); set_out(2, i-4); end
            3: if (i <= lim) rej = 1;
               else begin wr(i-1, d); put_top(d); set_out(1, i-2); set_out(2, i-3); end
            4: n = ni;
            5: if (ni >= MAXS) begin rej = 1; code = 3; end
               else begin wr(ni, d); n = ni + 1; put_top(d); set_out(1, ni-1); set_out(2, ni-2); end
            6: if (off >= i) rej = 1; else set_out(0, off);
            default: if (off >= i) rej = 1; else begin wr(off, d); put_top(d); end
        endcase
        if (rej)            m_status = code;
        else if (n < lim)   m_status = 4;
        else if (n == lim)  m_status = 1;
        else if (n == MAXS) m_status = 2;
        else                m_status = 0;
        m_idx = n;
    endtask

    task automatic step(input int o, input int d, input int off, input int lim,
                        input int ni, input bit rst, input string tag);
        op = 3'(o); data = 8'(d); offset = 2'(off);
        underflow_limit = 2'(lim); new_index = 2'(ni); reset = ~rst;
        @(posedge clk);
        #1;
        model(o, d, off, lim, ni, rst);
        check({tag, ".index"},  {30'd0, index},  32'(m_idx));
        check({tag, ".status"}, {29'd0, status}, 32'(m_status));
        if (m_ov[0]) check({tag, ".out"},  {24'd0, out},  32'(m_out[0]));
        if (m_ov[1]) check({tag, ".out1"}, {24'd0, out1}, 32'(m_out[1]));
        if (m_ov[2]) check({tag, ".out2"}, {24'd0, out2}, 32'(m_out[2]));
    endtask

    initial begin
        #1;
        check("powerup.index",  {30'd0, index},  32'd0);
        check("powerup.status", {29'd0, status}, 32'd1);

        step(0, 0, 0, 0, 0, 1, "reset");
        step(2, 0, 0, 0, 0, 0, "empty_pop");
        step(1, 0, 0, 0, 0, 0, "push0");
        step(1, 1, 0, 0, 0, 0, "push1");
        step(1, 2, 0, 0, 0, 0, "push2");
        check("full.out",    {24'd0, out},    32'd2);
        check("full.out2",   {24'd0, out2},   32'd0);
        check("full.status", {29'd0, status}, 32'd2);
        step(1, 3, 0, 0, 0, 0, "push_ovf");
        check("ovf.out", {24'd0, out}, 32'd2);
        step(2, 0, 0, 0, 0, 0, "pop_a");
        step(2, 0, 0, 0, 0, 0, "pop_b");
        step(2, 0, 0, 0, 0, 0, "pop_c");
        step(3, 4, 0, 0, 0, 0, "replace_empty");
        step(1, 5, 0, 0, 0, 0, "push5");
        step(3, 6, 0, 0, 0, 0, "replace6");
        check("replace6.out", {24'd0, out}, 32'd6);
        step(0, 0, 0, 0, 0, 1, "reset_mid");
        check("reset_mid.out", {24'd0, out}, 32'd6);
        step(0, 0, 0, 1, 0, 0, "frame_none");
        step(1, 8, 0, 1, 0, 0, "frame_push8");
        step(1, 9, 0, 1, 0, 0, "frame_push9");
        step(4, 0, 0, 1, 1, 0, "frame_ireset");
        step(2, 0, 0, 1, 0, 0, "frame_pop_uf");
        step(0, 0, 0, 0, 0, 0, "frame_lim0");
        step(2, 0, 0, 0, 0, 0, "frame_pop");
        step(5, 10, 0, 2, 0, 0, "irp_uf");
        check("irp_uf.status", {29'd0, status}, 32'd4);
        step(5, 11, 0, 0, 0, 0, "irp_ok");
        step(6, 0, 0, 0, 0, 0, "uf_get");
        step(7, 12, 0, 0, 0, 0, "uf_set");
        check("uf_set.out", {24'd0, out}, 32'h0c);
        step(5, 1, 0, 0, 3, 0, "irp_ovf");

        for (int k = 0; k < 400; k++) begin
            int o, lim;
            o   = int'($urandom_range(0, 7));
            lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0;
            step(o, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), lim,
                 int'($urandom_range(0, 3)), ($urandom_range(0, 40) == 0), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
